// File: rtl/seq_bcd_converter.sv
// seq_bcd_converter: sequential double-dabble binary-to-BCD converter with leading-zero blanking
module seq_bcd_converter #(
  parameter int WIDTH = 16,
  parameter int LZ_BLANK = 1,
  parameter logic [4:0] BLANK = 5'h10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] binary,
  output logic             busy,
  output logic             done,
  output logic [4:0]       D0,
  output logic [4:0]       D1,
  output logic [4:0]       D2,
  output logic [4:0]       D3,
  output logic [4:0]       D4
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, FINAL = 2'd2;
  localparam logic [4:0] LAST = 5'(WIDTH - 1);
  localparam logic [4:0] RB = (LZ_BLANK != 0) ? BLANK : 5'h00;
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d, adj;
  logic [4:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [24:0] dig_q, dig_d, fin;
  logic lead;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 5; i++)
      adj[4*i+:4] = (bcd_q[4*i+:4] >= 4'd5) ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    // Blank from the top down until the first nonzero digit; D0 always shows
    lead = (LZ_BLANK != 0);
    fin = {20'd0, 1'b0, bcd_q[3:0]};
    for (int i = 4; i >= 1; i--) begin
      lead = lead && (bcd_q[4*i+:4] == 4'd0);
      fin[5*i+:5] = lead ? BLANK : {1'b0, bcd_q[4*i+:4]};
    end
    state_d = state_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    dig_d = dig_q;
    if (state_q == IDLE && start) begin
      bin_d = binary;
      bcd_d = 20'd0;
      cnt_d = 5'd0;
      busy_d = 1'b1;
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d = cnt_q + 5'd1;
      state_d = (cnt_q == LAST) ? FINAL : SHIFT;
    end else if (state_q == FINAL) begin
      dig_d = fin;
      done_d = 1'b1;
      busy_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q <= '0;
      bcd_q <= 20'd0;
      cnt_q <= 5'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dig_q <= {RB, RB, RB, RB, 5'h00};
    end else begin
      state_q <= state_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dig_q <= dig_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign D0 = dig_q[4:0];
  assign D1 = dig_q[9:5];
  assign D2 = dig_q[14:10];
  assign D3 = dig_q[19:15];
  assign D4 = dig_q[24:20];
endmodule
